// File: rtl/ace_snoop_resp_collector_if.sv
// Snoop-collector signal bundle: control, per-master CR channel and combined response.
// The collector uses the slave modport; the snoop control FSM or a bench drives the master side.
interface ace_snoop_resp_collector_if #(
    parameter int NUM_MASTERS    = 8,
    parameter int CRRESP_BITSIZE = 5
);
    logic                                  snp_start;
    logic [NUM_MASTERS-1:0]                snp_mask;
    logic                                  snp_busy;
    logic [NUM_MASTERS-1:0]                CRVALID_in;
    logic [NUM_MASTERS*CRRESP_BITSIZE-1:0] CRRESP_in;
    logic [NUM_MASTERS-1:0]                CRREADY_out;
    logic                                  resp_valid;
    logic                                  resp_ready;
    logic [CRRESP_BITSIZE-1:0]             resp_combined;
    logic [NUM_MASTERS-1:0]                resp_data_mask;
    logic                                  resp_timeout;

    modport slave (
        input  snp_start, snp_mask, CRVALID_in, CRRESP_in, resp_ready,
        output snp_busy, CRREADY_out, resp_valid, resp_combined, resp_data_mask, resp_timeout
    );

    modport master (
        output snp_start, snp_mask, CRVALID_in, CRRESP_in, resp_ready,
        input  snp_busy, CRREADY_out, resp_valid, resp_combined, resp_data_mask, resp_timeout
    );
endinterface

// File: rtl/ace_snoop_resp_collector.sv
// Collects CR-channel snoop responses from the snooped masters and hands one ORed
// response (with data mask and timeout flag) to the interconnect on a valid/ready port.
module ace_snoop_resp_collector #(
    parameter int NUM_MASTERS    = 8,
    parameter int CRRESP_BITSIZE = 5,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                     ACLK,
    input logic                     ARESETn,
    ace_snoop_resp_collector_if.slave bus
);
    localparam int N  = NUM_MASTERS;
    localparam int W  = CRRESP_BITSIZE;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TLAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        RESPOND
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  dmask_q, dmask_d;
    logic [W-1:0]  accum_q, accum_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tflag_q, tflag_d;
    logic [N-1:0]  hs;
    logic [N-1:0]  left;
    logic [W-1:0]  hs_resp;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        dmask_d   = dmask_q;
        accum_d   = accum_q;
        tcnt_d    = tcnt_q;
        tflag_d   = tflag_q;
        hs        = (state_q == COLLECT) ? (bus.CRVALID_in & pending_q) : '0;
        left      = pending_q & ~hs;
        hs_resp   = '0;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                hs_resp = hs_resp | bus.CRRESP_in[i*W +: W];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.snp_start) begin
                    accum_d = '0;
                    dmask_d = '0;
                    tcnt_d  = '0;
                    tflag_d = 1'b0;
                    if (bus.snp_mask != '0) begin
                        pending_d = bus.snp_mask;
                        state_d   = COLLECT;
                    end else begin
                        state_d = RESPOND;
                    end
                end
            end
            COLLECT: begin
                pending_d = left;
                accum_d   = accum_q | hs_resp;
                tcnt_d    = tcnt_q + TW'(1);
                for (int i = 0; i < N; i++) begin
                    if (hs[i]) begin
                        dmask_d[i] = bus.CRRESP_in[i*W];
                    end
                end
                // Completion takes priority over a timeout landing on the same edge.
                if (left == '0) begin
                    state_d = RESPOND;
                end else if ((TIMEOUT_CYCLES != 0) && (tcnt_q == TLAST)) begin
                    state_d    = RESPOND;
                    tflag_d    = 1'b1;
                    accum_d[1] = 1'b1;
                    pending_d  = '0;
                end
            end
            RESPOND: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            pending_q <= '0;
            dmask_q   <= '0;
            accum_q   <= '0;
            tcnt_q    <= '0;
            tflag_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dmask_q   <= dmask_d;
            accum_q   <= accum_d;
            tcnt_q    <= tcnt_d;
            tflag_q   <= tflag_d;
        end
    end

    assign bus.snp_busy       = (state_q != IDLE);
    assign bus.CRREADY_out    = (state_q == COLLECT) ? pending_q : '0;
    assign bus.resp_valid     = (state_q == RESPOND);
    assign bus.resp_combined  = (state_q == RESPOND) ? accum_q : '0;
    assign bus.resp_data_mask = (state_q == RESPOND) ? dmask_q : '0;
    assign bus.resp_timeout   = (state_q == RESPOND) && tflag_q;
endmodule

// File: tb/tb_ace_snoop_resp_collector.sv
// Bench for the snoop response collector: directed vector table, hand-written timeout
// sequences, then randomized traffic against a transaction-level reference model.
module tb_ace_snoop_resp_collector;
    localparam int N  = 8;
    localparam int W  = 5;
    localparam int TO = 16;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;

    ace_snoop_resp_collector_if #(.NUM_MASTERS(N), .CRRESP_BITSIZE(W)) bus ();

    ace_snoop_resp_collector #(
        .NUM_MASTERS   (N),
        .CRRESP_BITSIZE(W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK   (ACLK),
        .ARESETn(ARESETn),
        .bus    (bus)
    );

    always #5 ACLK = ~ACLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic           rst_n;
        logic           start;
        logic [N-1:0]   mask;
        logic [N-1:0]   crvalid;
        logic [N*W-1:0] crresp;
        logic           ready;
        logic           busy;
        logic [N-1:0]   crready;
        logic           rv;
        logic [W-1:0]   comb;
        logic [N-1:0]   dm;
        logic           to;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: which masters still owe a response, and what has been gathered.
    bit           m_collect;
    bit           m_respond;
    bit           m_timed;
    bit           m_wait[N];
    int           m_cycles;
    logic [W-1:0] m_result;
    logic [N-1:0] m_data;

    task automatic addRow(input logic rst_n, start, input logic [N-1:0] mask, crvalid,
                          input logic [N*W-1:0] crresp, input logic ready,
                          input logic busy, input logic [N-1:0] crready, input logic rv,
                          input logic [W-1:0] comb, input logic [N-1:0] dm, input logic to);
        vec_t v;
        v.rst_n = rst_n; v.start = start; v.mask = mask; v.crvalid = crvalid;
        v.crresp = crresp; v.ready = ready; v.busy = busy; v.crready = crready;
        v.rv = rv; v.comb = comb; v.dm = dm; v.to = to;
        tbl.push_back(v);
    endtask

    task automatic applyStimulus(input logic rst_n, start, input logic [N-1:0] mask, crvalid,
                                 input logic [N*W-1:0] crresp, input logic ready);
        ARESETn        = rst_n;
        bus.snp_start  = start;
        bus.snp_mask   = mask;
        bus.CRVALID_in = crvalid;
        bus.CRRESP_in  = crresp;
        bus.resp_ready = ready;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic busy, input logic [N-1:0] crready,
                            input logic rv, input logic [W-1:0] comb, input logic [N-1:0] dm,
                            input logic to);
        checkOutput({tag, "_busy"},    64'(bus.snp_busy),       64'(busy));
        checkOutput({tag, "_crready"}, 64'(bus.CRREADY_out),    64'(crready));
        checkOutput({tag, "_rvalid"},  64'(bus.resp_valid),     64'(rv));
        checkOutput({tag, "_comb"},    64'(bus.resp_combined),  64'(comb));
        checkOutput({tag, "_dmask"},   64'(bus.resp_data_mask), 64'(dm));
        checkOutput({tag, "_timeout"}, 64'(bus.resp_timeout),   64'(to));
    endtask

    task automatic clockEdge();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
        for (int k = 0; k < n; k++) clockEdge();
    endtask

    task automatic modelStep(input logic rst_n, start, input logic [N-1:0] mask, crvalid,
                             input logic [N*W-1:0] crresp, input logic ready);
        int           left;
        logic [W-1:0] r;
        if (!rst_n) begin
            m_collect = 0; m_respond = 0; m_timed = 0; m_cycles = 0;
            m_result = '0; m_data = '0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
        end else if (m_respond) begin
            if (ready) m_respond = 0;
        end else if (m_collect) begin
            left = 0;
            for (int i = 0; i < N; i++) begin
                if (m_wait[i] && crvalid[i]) begin
                    r = crresp[i*W +: W];
                    m_result = m_result | r;
                    m_data[i] = r[0];
                    m_wait[i] = 0;
                end
            end
            for (int i = 0; i < N; i++) if (m_wait[i]) left++;
            m_cycles++;
            if (left == 0) begin
                m_collect = 0; m_respond = 1;
            end else if (m_cycles == TO) begin
                m_collect = 0; m_respond = 1; m_timed = 1; m_result[1] = 1'b1;
                for (int i = 0; i < N; i++) m_wait[i] = 0;
            end
        end else if (start) begin
            m_result = '0; m_data = '0; m_timed = 0; m_cycles = 0;
            if (mask == '0) begin
                m_respond = 1;
            end else begin
                m_collect = 1;
                for (int i = 0; i < N; i++) m_wait[i] = mask[i];
            end
        end
    endtask

    function automatic logic [N-1:0] modelReady();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) if (m_collect && m_wait[i]) v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N*W-1:0] resp;
        logic           rst_n, start, ready;
        logic [N-1:0]   mask, crvalid;
        int             pct;

        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
        clockEdge();
        clockEdge();

        //     rst start mask   crvalid crresp          rdy  busy crready rv comb      dmask  to
        addRow(0,  0,   8'h00, 8'h00,  40'h0,          0,   0,   8'h00,  0, 5'b00000, 8'h00, 0);
        addRow(1,  1,   8'h05, 8'h00,  40'h0,          0,   1,   8'h05,  0, 5'b00000, 8'h00, 0);
        addRow(1,  0,   8'h00, 8'h00,  40'h0,          0,   1,   8'h05,  0, 5'b00000, 8'h00, 0);
        addRow(1,  0,   8'h00, 8'h01,  40'h8,          0,   1,   8'h04,  0, 5'b00000, 8'h00, 0);
        addRow(1,  0,   8'h00, 8'h02,  40'h240,        0,   1,   8'h04,  0, 5'b00000, 8'h00, 0);
        addRow(1,  0,   8'h00, 8'h04,  40'h400,        0,   1,   8'h00,  1, 5'b01001, 8'h04, 0);
        addRow(1,  1,   8'hFF, 8'h00,  40'h0,          0,   1,   8'h00,  1, 5'b01001, 8'h04, 0);
        addRow(1,  1,   8'hFF, 8'h00,  40'h0,          0,   1,   8'h00,  1, 5'b01001, 8'h04, 0);
        addRow(1,  0,   8'h00, 8'h00,  40'h0,          0,   1,   8'h00,  1, 5'b01001, 8'h04, 0);
        addRow(1,  0,   8'h00, 8'h00,  40'h0,          1,   0,   8'h00,  0, 5'b00000, 8'h00, 0);
        addRow(1,  0,   8'h00, 8'h00,  40'h0,          0,   0,   8'h00,  0, 5'b00000, 8'h00, 0);
        addRow(1,  1,   8'h00, 8'h00,  40'h0,          0,   1,   8'h00,  1, 5'b00000, 8'h00, 0);
        addRow(1,  0,   8'h00, 8'h00,  40'h0,          1,   0,   8'h00,  0, 5'b00000, 8'h00, 0);
        addRow(1,  1,   8'h30, 8'h00,  40'h0,          0,   1,   8'h30,  0, 5'b00000, 8'h00, 0);
        addRow(0,  0,   8'h00, 8'h10,  40'h400000,     0,   0,   8'h00,  0, 5'b00000, 8'h00, 0);
        addRow(1,  0,   8'h00, 8'h30,  40'h400000,     0,   0,   8'h00,  0, 5'b00000, 8'h00, 0);
        addRow(1,  0,   8'h00, 8'h00,  40'h0,          0,   0,   8'h00,  0, 5'b00000, 8'h00, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            applyStimulus(tbl[k].rst_n, tbl[k].start, tbl[k].mask, tbl[k].crvalid, tbl[k].crresp, tbl[k].ready);
            clockEdge();
            checkAll($sformatf("vec%0d", k), tbl[k].busy, tbl[k].crready, tbl[k].rv,
                     tbl[k].comb, tbl[k].dm, tbl[k].to);
        end

        // All eight masters answer in one cycle; bit (i mod 5) from master i.
        applyStimulus(1'b1, 1'b1, 8'hFF, '0, '0, 1'b0);
        clockEdge();
        checkAll("all_start", 1, 8'hFF, 0, 5'b00000, 8'h00, 0);
        resp = '0;
        for (int i = 0; i < N; i++) resp[i*W +: W] = W'(1 << (i % W));
        applyStimulus(1'b1, 1'b0, '0, 8'hFF, resp, 1'b0);
        #1;
        checkOutput("all_crready_hs", 64'(bus.CRREADY_out), 64'(8'hFF));
        clockEdge();
        checkAll("all_resp", 1, 8'h00, 1, 5'b11111, 8'h21, 0);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1);
        clockEdge();
        checkAll("all_done", 0, 8'h00, 0, 5'b00000, 8'h00, 0);

        // Master 3 never answers: the collection times out after 16 COLLECT cycles.
        applyStimulus(1'b1, 1'b1, 8'h09, '0, '0, 1'b0);
        clockEdge();
        checkAll("to_start", 1, 8'h09, 0, 5'b00000, 8'h00, 0);
        applyStimulus(1'b1, 1'b0, '0, 8'h01, 40'h5, 1'b0);
        clockEdge();
        idleCycles(14);
        checkAll("to_edge15", 1, 8'h08, 0, 5'b00000, 8'h00, 0);
        clockEdge();
        checkAll("to_fire", 1, 8'h00, 1, 5'b00111, 8'h01, 1);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1);
        clockEdge();
        checkAll("to_done", 0, 8'h00, 0, 5'b00000, 8'h00, 0);

        // Last response lands on the timeout edge: counts as a normal completion.
        applyStimulus(1'b1, 1'b1, 8'h02, '0, '0, 1'b0);
        clockEdge();
        idleCycles(15);
        checkAll("edge_wait", 1, 8'h02, 0, 5'b00000, 8'h00, 0);
        applyStimulus(1'b1, 1'b0, '0, 8'h02, 40'h200, 1'b0);
        clockEdge();
        checkAll("edge_complete", 1, 8'h00, 1, 5'b10000, 8'h00, 0);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1);
        clockEdge();

        // A response on the timeout edge is merged even though another master is still missing.
        applyStimulus(1'b1, 1'b1, 8'h06, '0, '0, 1'b0);
        clockEdge();
        idleCycles(15);
        applyStimulus(1'b1, 1'b0, '0, 8'h02, 40'h20, 1'b0);
        clockEdge();
        checkAll("edge_merge", 1, 8'h00, 1, 5'b00011, 8'h02, 1);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1);
        clockEdge();
        checkAll("edge_merge_done", 0, 8'h00, 0, 5'b00000, 8'h00, 0);

        // Randomized traffic with varying responsiveness, compared against the model.
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
        modelStep(1'b0, 1'b0, '0, '0, '0, 1'b0);
        clockEdge();
        for (int c = 0; c < 3000; c++) begin
            case ((c / 250) % 3)
                0:       pct = 6;
                1:       pct = 35;
                default: pct = 85;
            endcase
            rst_n = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 99) < 40);
            mask  = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom());
            for (int i = 0; i < N; i++) crvalid[i] = ($urandom_range(0, 99) < pct);
            for (int i = 0; i < N; i++) resp[i*W +: W] = W'($urandom());
            ready = 1'($urandom_range(0, 1));
            applyStimulus(rst_n, start, mask, crvalid, resp, ready);
            modelStep(rst_n, start, mask, crvalid, resp, ready);
            clockEdge();
            checkAll($sformatf("rnd%0d", c), m_collect | m_respond, modelReady(), m_respond,
                     m_respond ? m_result : '0, m_respond ? m_data : '0, m_respond & m_timed);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
